pattern_fsm: RTL

PATTERN_FSM -- requirements
Module: pattern_fsm

---
 rtl/pattern_fsm.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pattern_fsm.sv
// Serial pattern detector with a loadable pattern, optional overlapping detection
// and a saturating match counter. The state is the length of the longest suffix of
// accepted bits that is also a prefix of the pattern.
module pattern_fsm #(
    parameter int unsigned          LEN           = 4,
    parameter int unsigned          CNT_W         = 8,
    parameter bit                   OVERLAP       = 1'b1,
    parameter logic [LEN-1:0]       RESET_PATTERN = 4'b1011
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x,
    input  logic                     x_valid,
    input  logic                     load,
    input  logic [LEN-1:0]           pattern_in,
    input  logic                     clr_count,
    output logic                     z,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(LEN+1)-1:0] progress
);

    localparam int unsigned PW   = $clog2(LEN + 1);
    localparam int          LenI = int'(LEN);

    // Enough encodings for the largest legal pattern; unused ones are unreachable.
    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, P7} state_e;

    state_e             state_q, state_d;
    logic [LEN-1:0]     pat_q, pat_d;
    logic [LEN-2:0]     hist_q, hist_d;   // last LEN-1 accepted bits, newest in bit 0
    logic [PW-1:0]      hcnt_q, hcnt_d;   // how many of hist_q belong to the current run
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN-1:0]     hist_shift;
    int                 avail;
    int                 l_len;
    int                 border;
    logic               ok;
    logic               match;

    // Suffix/prefix search over the accepted bits, plus the pattern's own border.
    always_comb begin
        hist_shift = {hist_q, x};
        avail      = int'(hcnt_q) + 1;
        l_len      = 0;
        ok         = 1'b0;
        for (int k = 1; k <= LenI; k++) begin
            if (k <= avail) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist_shift[i] != pat_q[LenI-k+i]) ok = 1'b0;
                end
                if (ok) l_len = k;
            end
        end
        // Longest proper suffix of the pattern that is also its prefix.
        border = 0;
        for (int k = 1; k < LenI; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pat_q[i] != pat_q[LenI-k+i]) ok = 1'b0;
            end
            if (ok) border = k;
        end
    end

    // Next-state, pulse and counter logic; load pre-empts the data bit.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        hcnt_d  = hcnt_q;
        cnt_d   = cnt_q;
        z_d     = 1'b0;
        match   = 1'b0;

        if (load) begin
            pat_d   = pattern_in;
            state_d = P0;
            hist_d  = '0;
            hcnt_d  = '0;
        end else if (x_valid) begin
            hist_d = hist_shift[LEN-2:0];
            hcnt_d = (avail > LenI - 1) ? PW'(LenI - 1) : PW'(avail);
            if (l_len == LenI) begin
                match = 1'b1;
                z_d   = 1'b1;
                if (OVERLAP) begin
                    state_d = state_e'(border[2:0]);
                end else begin
                    state_d = P0;
                    hist_d  = '0;
                    hcnt_d  = '0;
                end
            end else begin
                state_d = state_e'(l_len[2:0]);
            end
        end

        if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        // Clear beats a simultaneous match; the z pulse is unaffected.
        if (clr_count) cnt_d = '0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= P0;
            pat_q   <= RESET_PATTERN;
            hist_q  <= '0;
            hcnt_q  <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            hcnt_q  <= hcnt_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign progress    = PW'(state_q);

endmodule
